// File: rtl/phase_addr_gen.sv
// Phase-accumulator ROM address generator with an optional phase offset.
// Runs continuously or for a counted number of waveform periods.
module phase_addr_gen #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int ACC_WIDTH     = 16,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     en,
  input  logic [ACC_WIDTH-1:0]     incr,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  input  logic [CNT_WIDTH-1:0]     num_periods,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     addr_valid,
  output logic                     busy,
  output logic                     wrap,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     valid_q, valid_d;
  logic                     wrap_q, wrap_d;
  logic                     done_q, done_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]     target_q, target_d;

  logic [ACC_WIDTH:0]       sum_s;
  logic                     carry_s;
  logic [CNT_WIDTH-1:0]     cnt_inc_s;

  assign sum_s     = {1'b0, acc_q} + {1'b0, incr};
  assign carry_s   = sum_s[ACC_WIDTH];
  // Period counter saturates rather than rolling back to zero.
  assign cnt_inc_s = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    addr_d   = addr_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        if (start) begin
          target_d = num_periods;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // stop wins over both advancing and a burst-completing wrap.
        if (stop) begin
          acc_d   = '0;
          state_d = S_IDLE;
        end else if (en) begin
          acc_d   = sum_s[ACC_WIDTH-1:0];
          addr_d  = sum_s[ACC_WIDTH-1 -: ADDRESS_WIDTH] + offset;
          valid_d = 1'b1;
          wrap_d  = carry_s;
          if (carry_s) begin
            cnt_d = cnt_inc_s;
            if ((target_q != '0) && (cnt_inc_s == target_q)) begin
              state_d = S_FINISH;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        acc_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        acc_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign wrap       = wrap_q;
  assign done       = done_q;
  assign busy       = (state_q == S_RUN);

endmodule

// File: tb/tb_phase_addr_gen.sv
// Self-checking bench for phase_addr_gen: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_phase_addr_gen;

  logic        clk = 1'b0;
  logic        rst, start, stop, en;
  logic [15:0] incr;
  logic [7:0]  offset, num_periods;
  logic [7:0]  addr;
  logic        addr_valid, busy, wrap, done;

  int passed = 0;
  int total  = 0;

  // Reference model: phase as a plain integer, mode 0 idle / 1 run / 2 finish.
  int          m_phase, m_mode, m_count, m_target;
  logic [7:0]  e_addr;
  logic        e_valid, e_wrap, e_done, e_busy;

  phase_addr_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
    .incr(incr), .offset(offset), .num_periods(num_periods),
    .addr(addr), .addr_valid(addr_valid), .busy(busy), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  task automatic reset_model();
    m_phase = 0; m_mode = 0; m_count = 0; m_target = 0;
    e_addr = 8'd0; e_valid = 1'b0; e_wrap = 1'b0; e_done = 1'b0; e_busy = 1'b0;
  endtask

  task automatic tick();
    int sum;
    @(posedge clk);
    e_wrap = 1'b0;
    e_done = 1'b0;
    if (m_mode == 0) begin
      e_valid = 1'b0;
      m_phase = 0;
      if (start) begin
        m_mode = 1; m_target = num_periods; m_count = 0;
      end
    end else if (m_mode == 1) begin
      if (stop) begin
        m_mode = 0; e_valid = 1'b0; m_phase = 0;
      end else if (en) begin
        sum     = m_phase + int'(incr);
        e_wrap  = (sum >= 65536);
        m_phase = sum % 65536;
        e_addr  = 8'(((m_phase / 256) + int'(offset)) % 256);
        e_valid = 1'b1;
        if (e_wrap) begin
          if (m_count < 255) m_count = m_count + 1;
          if (m_target != 0 && m_count == m_target) m_mode = 2;
        end
      end else begin
        e_valid = 1'b0;
      end
    end else begin
      e_done = 1'b1; e_valid = 1'b0; m_phase = 0; m_mode = 0;
    end
    e_busy = (m_mode == 1);
    #1;
  endtask

  task automatic begin_run(input logic [15:0] inc, input logic [7:0] off, input logic [7:0] np);
    incr = inc; offset = off; num_periods = np; en = 1'b1; stop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_run();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0;
    incr = 16'd0; offset = 8'd0; num_periods = 8'd0;
    reset_model();
    #1;
    total++;
    if ({addr, addr_valid, busy, wrap, done} !== 12'd0) begin
      $display("FAIL reset_initial: got %h want 000", {addr, addr_valid, busy, wrap, done});
    end else passed++;
    @(negedge clk);
    rst = 1'b0;
    begin_run(16'h0100, 8'h00, 8'd0);
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (addr !== 8'd5 || busy !== 1'b1) begin
      $display("FAIL reset_prerun: got addr=%0d busy=%b want addr=5 busy=1", addr, busy);
    end else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({addr, addr_valid, busy, wrap, done} !== 12'd0) begin
      $display("FAIL reset_async: got %h want 000", {addr, addr_valid, busy, wrap, done});
    end else passed++;
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (busy !== 1'b0 || addr_valid !== 1'b0 || addr !== 8'd0) begin
        $display("FAIL reset_stays_idle: got busy=%b valid=%b addr=%0d want 0 0 0", busy, addr_valid, addr);
      end else passed++;
    end
  endtask

  task automatic test_basic();
    int wraps = 0;
    begin_run(16'h0100, 8'h00, 8'd0);
    for (int k = 0; k < 258; k++) begin
      tick();
      if (wrap === 1'b1) wraps++;
      total++;
      if (addr !== 8'(k + 1) || addr_valid !== 1'b1) begin
        $display("FAIL basic_seq[%0d]: got addr=%0d valid=%b want addr=%0d valid=1", k, addr, addr_valid, 8'(k + 1));
      end else passed++;
    end
    total++;
    if (wraps !== 1) begin
      $display("FAIL basic_wraps: got %0d want 1", wraps);
    end else passed++;
    end_run();
  endtask

  task automatic test_fractional();
    int wraps = 0;
    begin_run(16'h0080, 8'h40, 8'd0);
    for (int k = 0; k < 520; k++) begin
      tick();
      if (wrap === 1'b1) wraps++;
      total++;
      if (addr !== 8'(64 + (((k + 1) * 128) >> 8))) begin
        $display("FAIL frac_seq[%0d]: got %h want %h", k, addr, 8'(64 + (((k + 1) * 128) >> 8)));
      end else passed++;
    end
    total++;
    if (wraps !== 1) begin
      $display("FAIL frac_wraps: got %0d want 1", wraps);
    end else passed++;
    end_run();
  endtask

  task automatic test_burst();
    logic [7:0] exp_seq [8];
    exp_seq = '{8'h40, 8'h80, 8'hC0, 8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
    begin_run(16'h4000, 8'h00, 8'd2);
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (addr !== exp_seq[k] || addr_valid !== 1'b1 || done !== 1'b0) begin
        $display("FAIL burst_seq[%0d]: got addr=%h valid=%b done=%b want addr=%h valid=1 done=0", k, addr, addr_valid, done, exp_seq[k]);
      end else passed++;
    end
    tick();
    total++;
    if ({done, busy, addr_valid} !== 3'b100) begin
      $display("FAIL burst_done: got done/busy/valid=%b want 100", {done, busy, addr_valid});
    end else passed++;
    tick();
    total++;
    if ({done, busy, addr_valid} !== 3'b000) begin
      $display("FAIL burst_after: got done/busy/valid=%b want 000", {done, busy, addr_valid});
    end else passed++;
  endtask

  task automatic test_pause();
    begin_run(16'h0100, 8'h00, 8'd0);
    for (int k = 0; k < 10; k++) tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (addr !== 8'd10 || addr_valid !== 1'b0) begin
        $display("FAIL pause_hold[%0d]: got addr=%0d valid=%b want addr=10 valid=0", k, addr, addr_valid);
      end else passed++;
    end
    en = 1'b1;
    tick();
    total++;
    if (addr !== 8'd11 || addr_valid !== 1'b1) begin
      $display("FAIL pause_resume: got addr=%0d valid=%b want addr=11 valid=1", addr, addr_valid);
    end else passed++;
    end_run();
  endtask

  task automatic test_stop_completion();
    begin_run(16'h4000, 8'h00, 8'd1);
    for (int k = 0; k < 3; k++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if ({busy, addr_valid, wrap, done} !== 4'b0000) begin
      $display("FAIL stop_priority: got busy/valid/wrap/done=%b want 0000", {busy, addr_valid, wrap, done});
    end else passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL stop_no_done[%0d]: got done=%b busy=%b want 0 0", k, done, busy);
      end else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      en    = ($urandom_range(0, 4) != 0);
      num_periods = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 3))
          0:       incr = 16'd0;
          1:       incr = 16'($urandom_range(1, 1023));
          default: incr = 16'($urandom_range(4096, 65535));
        endcase
      end
      if ($urandom_range(0, 31) == 0) offset = 8'($urandom_range(0, 255));
      tick();
      total++;
      if ({addr, addr_valid, busy, wrap, done} !== {e_addr, e_valid, e_busy, e_wrap, e_done}) begin
        $display("FAIL random[%0d]: got addr=%h v=%b b=%b w=%b d=%b want addr=%h v=%b b=%b w=%b d=%b",
                 i, addr, addr_valid, busy, wrap, done, e_addr, e_valid, e_busy, e_wrap, e_done);
      end else passed++;
    end
    start = 1'b0;
    end_run();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fractional();
    test_burst();
    test_pause();
    test_stop_completion();
    incr = 16'h5000;
    offset = 8'h00;
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
